// File: rtl/img_rsz_blk_acc_if.sv
// Pixel-stream and block-output bundle for the resize block accumulator.
// The master side produces pixels and consumes blocks. The slave side is
// the accumulator itself.
interface img_rsz_blk_acc_if #(
  parameter int PXL_W     = 8,
  parameter int COLOR_NUM = 3,
  parameter int SUM_W     = 20,
  parameter int RSZ_W_MAX = 64,
  parameter int RSZ_H_MAX = 64
);
  logic [COLOR_NUM*PXL_W-1:0] PxlData;
  logic                       PxlVld;
  logic                       PxlRdy;
  logic                       IsFstPxl;
  logic [COLOR_NUM*SUM_W-1:0] CompBlkData;
  logic [RSZ_W_MAX-1:0]       CompBlkXMsk;
  logic [RSZ_H_MAX-1:0]       CompBlkYMsk;
  logic                       CompBlkVld;
  logic                       CompBlkRdy;

  modport master (
    output PxlData, PxlVld, IsFstPxl, CompBlkRdy,
    input  PxlRdy, CompBlkData, CompBlkXMsk, CompBlkYMsk, CompBlkVld
  );

  modport slave (
    input  PxlData, PxlVld, IsFstPxl, CompBlkRdy,
    output PxlRdy, CompBlkData, CompBlkXMsk, CompBlkYMsk, CompBlkVld
  );
endinterface

// File: rtl/img_rsz_blk_acc.sv
// Image resize block accumulator. It sums the colours of each
// BlkSzHor x BlkSzVer pixel block of a raster stream and emits one sum per
// block, tagged with one-hot column and row masks.
// Optional feature: define IMG_RSZ_BLK_ACC_SAT_EN to saturate the colour sums
// and raise the sticky AccOvf flag. Without it, the sums wrap and AccOvf is 0.
module img_rsz_blk_acc #(
  parameter int PXL_W     = 8,
  parameter int COLOR_NUM = 3,
  parameter int SUM_W     = 20,
  parameter int RSZ_W_MAX = 64,
  parameter int RSZ_H_MAX = 64,
  parameter int BLK_W_W   = 8,
  parameter int BLK_H_W   = 8
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               CompEngRdy,
  input  logic [BLK_W_W-1:0]                 BlkSzHor,
  input  logic [BLK_H_W-1:0]                 BlkSzVer,
  input  logic [$clog2(RSZ_W_MAX+1)-1:0]     RszWidth,
  input  logic [$clog2(RSZ_H_MAX+1)-1:0]     RszHeight,
  img_rsz_blk_acc_if.slave                   Bus,
  output logic                               FrmDone,
  output logic                               AccOvf
);
  localparam int XW  = $clog2(RSZ_W_MAX+1);
  localparam int YW  = $clog2(RSZ_H_MAX+1);
  localparam int XIW = (RSZ_W_MAX > 1) ? $clog2(RSZ_W_MAX) : 1;
  localparam int YIW = (RSZ_H_MAX > 1) ? $clog2(RSZ_H_MAX) : 1;
  localparam logic [RSZ_W_MAX-1:0] X_ONE = RSZ_W_MAX'(1);
  localparam logic [RSZ_H_MAX-1:0] Y_ONE = RSZ_H_MAX'(1);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH} state_t;
  state_t state;

  // Frame geometry captured when the frame starts.
  logic [BLK_W_W-1:0] szHor;
  logic [BLK_H_W-1:0] szVer;
  logic [XW-1:0]      rszW;
  logic [YW-1:0]      rszH;

  // Raster position counters.
  logic [BLK_W_W-1:0] horCnt;
  logic [BLK_H_W-1:0] verCnt;
  logic [XW-1:0]      blkX;
  logic [YW-1:0]      blkY;

  // One running sum per block column and colour.
  logic [SUM_W-1:0] acc [RSZ_W_MAX][COLOR_NUM];

  // Registered block output.
  logic [COLOR_NUM*SUM_W-1:0] compData_p1;
  logic [RSZ_W_MAX-1:0]       xMsk_p1;
  logic [RSZ_H_MAX-1:0]       yMsk_p1;
  logic                       vld_p1;

  logic pxlAcc, blkHs, frmStart;
  logic [BLK_W_W-1:0] curHor, nxtHor;
  logic [BLK_H_W-1:0] curVer, nxtVer;
  logic [XW-1:0]      curX, nxtX;
  logic [YW-1:0]      curY, nxtY;
  logic [XIW-1:0]     curXi;
  logic [YIW-1:0]     curYi;
  logic horEnd, verEnd, colEnd, rowEnd, blkLast, frmLast;
  logic [SUM_W-1:0]   sumNew [COLOR_NUM];
  logic [COLOR_NUM*SUM_W-1:0] sumPacked;

  function automatic logic [SUM_W-1:0] addWrap(input logic [SUM_W-1:0] a,
                                               input logic [PXL_W-1:0] p);
    return a + SUM_W'(p);
  endfunction

`ifdef IMG_RSZ_BLK_ACC_SAT_EN
  function automatic logic addOvf(input logic [SUM_W-1:0] a,
                                  input logic [PXL_W-1:0] p);
    return ({1'b0, a} + (SUM_W+1)'(p)) > {1'b0, {SUM_W{1'b1}}};
  endfunction

  function automatic logic [SUM_W-1:0] addSum(input logic [SUM_W-1:0] a,
                                              input logic [PXL_W-1:0] p);
    return addOvf(a, p) ? {SUM_W{1'b1}} : addWrap(a, p);
  endfunction

  logic ovfHit;
`else
  function automatic logic [SUM_W-1:0] addSum(input logic [SUM_W-1:0] a,
                                              input logic [PXL_W-1:0] p);
    return addWrap(a, p);
  endfunction
`endif

  assign pxlAcc   = Bus.PxlVld && Bus.PxlRdy;
  assign blkHs    = vld_p1 && Bus.CompBlkRdy;
  assign frmStart = (state == IDLE) && CompEngRdy;

  assign Bus.PxlRdy      = (state == ACC) && !(vld_p1 && !Bus.CompBlkRdy);
  assign Bus.CompBlkData = compData_p1;
  assign Bus.CompBlkXMsk = xMsk_p1;
  assign Bus.CompBlkYMsk = yMsk_p1;
  assign Bus.CompBlkVld  = vld_p1;
  assign FrmDone         = (state == FLUSH) && blkHs;

  // Current position and updated sums for the pixel at the input. A first-pixel
  // marker makes the pixel start block (0,0) from empty sums.
  always_comb begin
    curHor = Bus.IsFstPxl ? '0 : horCnt;
    curVer = Bus.IsFstPxl ? '0 : verCnt;
    curX   = Bus.IsFstPxl ? '0 : blkX;
    curY   = Bus.IsFstPxl ? '0 : blkY;
    curXi  = curX[XIW-1:0];
    curYi  = curY[YIW-1:0];
    horEnd = (curHor == szHor - BLK_W_W'(1));
    verEnd = (curVer == szVer - BLK_H_W'(1));
    colEnd = (curX == rszW - XW'(1));
    rowEnd = (curY == rszH - YW'(1));
    blkLast = horEnd && verEnd;
    frmLast = blkLast && colEnd && rowEnd;
    sumPacked = '0;
`ifdef IMG_RSZ_BLK_ACC_SAT_EN
    ovfHit = 1'b0;
`endif
    for (int c = 0; c < COLOR_NUM; c++) begin
      sumNew[c] = addSum(Bus.IsFstPxl ? '0 : acc[curXi][c],
                         Bus.PxlData[c*PXL_W +: PXL_W]);
      sumPacked[c*SUM_W +: SUM_W] = sumNew[c];
`ifdef IMG_RSZ_BLK_ACC_SAT_EN
      ovfHit = ovfHit | addOvf(Bus.IsFstPxl ? '0 : acc[curXi][c],
                               Bus.PxlData[c*PXL_W +: PXL_W]);
`endif
    end
    nxtHor = curHor + BLK_W_W'(1);
    nxtVer = curVer;
    nxtX   = curX;
    nxtY   = curY;
    if (horEnd) begin
      nxtHor = '0;
      if (colEnd) begin
        nxtX = '0;
        if (verEnd) begin
          nxtVer = '0;
          nxtY   = rowEnd ? '0 : curY + YW'(1);
        end else begin
          nxtVer = curVer + BLK_H_W'(1);
        end
      end else begin
        nxtX = curX + XW'(1);
      end
    end
  end

  // Frame control FSM, geometry capture and raster counters.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      szHor  <= '0;
      szVer  <= '0;
      rszW   <= '0;
      rszH   <= '0;
      horCnt <= '0;
      verCnt <= '0;
      blkX   <= '0;
      blkY   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CompEngRdy) begin
            state  <= ACC;
            szHor  <= BlkSzHor;
            szVer  <= BlkSzVer;
            rszW   <= RszWidth;
            rszH   <= RszHeight;
            horCnt <= '0;
            verCnt <= '0;
            blkX   <= '0;
            blkY   <= '0;
          end
        end
        ACC: begin
          if (pxlAcc) begin
            horCnt <= nxtHor;
            verCnt <= nxtVer;
            blkX   <= nxtX;
            blkY   <= nxtY;
            if (frmLast) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (blkHs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Column accumulators. A completed block's column restarts from zero, and a
  // first-pixel marker empties every column before the pixel lands.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int x = 0; x < RSZ_W_MAX; x++)
        for (int c = 0; c < COLOR_NUM; c++) acc[x][c] <= '0;
    end else if (frmStart) begin
      for (int x = 0; x < RSZ_W_MAX; x++)
        for (int c = 0; c < COLOR_NUM; c++) acc[x][c] <= '0;
    end else if (pxlAcc) begin
      if (Bus.IsFstPxl) begin
        for (int x = 0; x < RSZ_W_MAX; x++)
          for (int c = 0; c < COLOR_NUM; c++) acc[x][c] <= '0;
      end
      for (int c = 0; c < COLOR_NUM; c++)
        acc[curXi][c] <= blkLast ? '0 : sumNew[c];
    end
  end

  // ---- stage p1: block output register, held until it is consumed ----
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      compData_p1 <= '0;
      xMsk_p1     <= '0;
      yMsk_p1     <= '0;
      vld_p1      <= 1'b0;
    end else if (pxlAcc && blkLast) begin
      compData_p1 <= sumPacked;
      xMsk_p1     <= X_ONE << curXi;
      yMsk_p1     <= Y_ONE << curYi;
      vld_p1      <= 1'b1;
    end else if (blkHs) begin
      vld_p1      <= 1'b0;
    end
  end

`ifdef IMG_RSZ_BLK_ACC_SAT_EN
  logic ovfSticky;

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                 ovfSticky <= 1'b0;
    else if (pxlAcc && ovfHit)  ovfSticky <= 1'b1;
  end

  assign AccOvf = ovfSticky;
`else
  assign AccOvf = 1'b0;
`endif
endmodule

// File: tb/tb_img_rsz_blk_acc.sv
// Directed bench for img_rsz_blk_acc: basic frame, back-pressure, first-pixel
// restart, sum overflow (on a SUM_W=10 instance), mid-frame reset and 1x1 blocks.
module tb_img_rsz_blk_acc;
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       Reset = 1'b0;
  logic       CompEngRdy = 1'b0, CompEngRdy2 = 1'b0;
  logic [7:0] BlkSzHor = 8'd1, BlkSzVer = 8'd1, BlkSzHor2 = 8'd1, BlkSzVer2 = 8'd1;
  logic [6:0] RszWidth = 7'd1, RszHeight = 7'd1, RszWidth2 = 7'd1, RszHeight2 = 7'd1;
  logic       FrmDone, AccOvf, FrmDone2, AccOvf2;

  img_rsz_blk_acc_if bus ();
  img_rsz_blk_acc_if #(.SUM_W(10)) bus2 ();

  img_rsz_blk_acc dut (
    .Clk(Clk), .Reset(Reset), .CompEngRdy(CompEngRdy),
    .BlkSzHor(BlkSzHor), .BlkSzVer(BlkSzVer),
    .RszWidth(RszWidth), .RszHeight(RszHeight),
    .Bus(bus), .FrmDone(FrmDone), .AccOvf(AccOvf)
  );

  img_rsz_blk_acc #(.SUM_W(10)) dut2 (
    .Clk(Clk), .Reset(Reset), .CompEngRdy(CompEngRdy2),
    .BlkSzHor(BlkSzHor2), .BlkSzVer(BlkSzVer2),
    .RszWidth(RszWidth2), .RszHeight(RszHeight2),
    .Bus(bus2), .FrmDone(FrmDone2), .AccOvf(AccOvf2)
  );

  int vecCnt = 0;
  int errCnt = 0;
  int cyc = 0;
  int fdCnt = 0;

  typedef struct {
    logic [59:0] d;
    logic [63:0] xm;
    logic [63:0] ym;
    logic        fd;
    int          cyc;
  } blk_t;
  blk_t blkQ[$];

  // Record every completed block handshake of the main instance.
  always @(negedge Clk) begin
    blk_t b;
    cyc++;
    if (bus.CompBlkVld && bus.CompBlkRdy) begin
      b.d = bus.CompBlkData; b.xm = bus.CompBlkXMsk; b.ym = bus.CompBlkYMsk;
      b.fd = FrmDone; b.cyc = cyc;
      blkQ.push_back(b);
    end
    if (FrmDone) fdCnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [23:0] pix(input logic [7:0] v);
    return {v, v, v};
  endfunction

  function automatic logic [23:0] pk(input int k);
    logic [7:0] a, b;
    a = 8'(k + 1);
    b = 8'(2 * (k + 1));
    return {8'd200, b, a};
  endfunction

  function automatic logic [59:0] s3(input int v);
    logic [19:0] t;
    t = 20'(v);
    return {t, t, t};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic startFrame(input logic [7:0] h, input logic [7:0] v,
                            input logic [6:0] w, input logic [6:0] ht);
    BlkSzHor = h; BlkSzVer = v; RszWidth = w; RszHeight = ht;
    CompEngRdy = 1'b1;
    @(posedge Clk); #1;
    CompEngRdy = 1'b0;
  endtask

  task automatic pushPx(input logic [23:0] d, input logic fst);
    logic ok;
    ok = 1'b0;
    bus.PxlData = d; bus.IsFstPxl = fst; bus.PxlVld = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge Clk); ok = bus.PxlRdy;
      @(posedge Clk); #1;
    end
    if (!ok) begin
      vecCnt++; errCnt++;
      $display("FAIL pxl_accept_timeout PxlRdy stayed 0, want 1");
    end
    bus.IsFstPxl = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    idle(3);
    @(negedge Clk);
    vecCnt++; if (bus.PxlRdy !== 1'b0) begin errCnt++; $display("FAIL rst_pxlrdy got %b want 0", bus.PxlRdy); end
    vecCnt++; if (bus.CompBlkVld !== 1'b0) begin errCnt++; $display("FAIL rst_vld got %b want 0", bus.CompBlkVld); end
    vecCnt++; if (bus.CompBlkData !== 60'd0) begin errCnt++; $display("FAIL rst_data got %h want 0", bus.CompBlkData); end
    vecCnt++; if ({bus.CompBlkXMsk, bus.CompBlkYMsk} !== 128'd0) begin errCnt++; $display("FAIL rst_masks got %h/%h want 0/0", bus.CompBlkXMsk, bus.CompBlkYMsk); end
    vecCnt++; if (FrmDone !== 1'b0) begin errCnt++; $display("FAIL rst_frmdone got %b want 0", FrmDone); end
    vecCnt++; if (AccOvf !== 1'b0) begin errCnt++; $display("FAIL rst_accovf got %b want 0", AccOvf); end
    @(posedge Clk); #1;
    Reset = 1'b1;
    idle(2);
    @(negedge Clk);
    vecCnt++; if (bus.PxlRdy !== 1'b0) begin errCnt++; $display("FAIL idle_pxlrdy got %b want 0", bus.PxlRdy); end
    @(posedge Clk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] ex[4];
    logic [63:0] ey[4];
    ex = '{64'd1, 64'd2, 64'd1, 64'd2};
    ey = '{64'd1, 64'd1, 64'd2, 64'd2};
    blkQ.delete(); fdCnt = 0; bus.CompBlkRdy = 1'b1;
    bus.PxlData = pix(8'd99); bus.IsFstPxl = 1'b1; bus.PxlVld = 1'b1;
    idle(3);
    bus.PxlVld = 1'b0; bus.IsFstPxl = 1'b0;
    startFrame(8'd2, 8'd2, 7'd2, 7'd2);
    for (int k = 0; k < 16; k++) pushPx(pix(8'd10), 1'b0);
    bus.PxlVld = 1'b0;
    idle(3);
    vecCnt++; if (blkQ.size() != 4) begin errCnt++; $display("FAIL basic_count got %0d want 4", blkQ.size()); end
    for (int i = 0; i < blkQ.size() && i < 4; i++) begin
      vecCnt++; if (blkQ[i].d !== s3(40)) begin errCnt++; $display("FAIL basic_sum[%0d] got %h want %h", i, blkQ[i].d, s3(40)); end
      vecCnt++; if (blkQ[i].xm !== ex[i] || blkQ[i].ym !== ey[i]) begin errCnt++; $display("FAIL basic_mask[%0d] got %h/%h want %h/%h", i, blkQ[i].xm, blkQ[i].ym, ex[i], ey[i]); end
      vecCnt++; if (blkQ[i].fd !== (i == 3)) begin errCnt++; $display("FAIL basic_frmdone[%0d] got %b want %b", i, blkQ[i].fd, (i == 3)); end
    end
    vecCnt++; if (fdCnt != 1) begin errCnt++; $display("FAIL basic_frmdone_cnt got %0d want 1", fdCnt); end
    vecCnt++; if (AccOvf !== 1'b0) begin errCnt++; $display("FAIL basic_accovf got %b want 0", AccOvf); end
  endtask

  task automatic test_backpressure();
    logic [59:0] exd[4];
    logic [63:0] ex[4];
    logic [63:0] ey[4];
    exd = '{{20'd800, 20'd28, 20'd14}, {20'd800, 20'd44, 20'd22},
            {20'd800, 20'd92, 20'd46}, {20'd800, 20'd108, 20'd54}};
    ex = '{64'd1, 64'd2, 64'd1, 64'd2};
    ey = '{64'd1, 64'd1, 64'd2, 64'd2};
    blkQ.delete(); fdCnt = 0; bus.CompBlkRdy = 1'b0;
    startFrame(8'd2, 8'd2, 7'd2, 7'd2);
    for (int k = 0; k < 6; k++) pushPx(pk(k), 1'b0);
    bus.PxlData = pk(6); bus.PxlVld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      vecCnt++; if (bus.PxlRdy !== 1'b0) begin errCnt++; $display("FAIL stall_pxlrdy[%0d] got %b want 0", i, bus.PxlRdy); end
      vecCnt++; if (bus.CompBlkVld !== 1'b1 || bus.CompBlkData !== exd[0]) begin errCnt++; $display("FAIL stall_data[%0d] got %b/%h want 1/%h", i, bus.CompBlkVld, bus.CompBlkData, exd[0]); end
      vecCnt++; if (bus.CompBlkXMsk !== 64'd1 || bus.CompBlkYMsk !== 64'd1) begin errCnt++; $display("FAIL stall_mask[%0d] got %h/%h want 1/1", i, bus.CompBlkXMsk, bus.CompBlkYMsk); end
      @(posedge Clk); #1;
    end
    bus.CompBlkRdy = 1'b1;
    for (int k = 6; k < 16; k++) pushPx(pk(k), 1'b0);
    bus.PxlVld = 1'b0;
    idle(3);
    vecCnt++; if (blkQ.size() != 4) begin errCnt++; $display("FAIL bp_count got %0d want 4", blkQ.size()); end
    for (int i = 0; i < blkQ.size() && i < 4; i++) begin
      vecCnt++; if (blkQ[i].d !== exd[i]) begin errCnt++; $display("FAIL bp_sum[%0d] got %h want %h", i, blkQ[i].d, exd[i]); end
      vecCnt++; if (blkQ[i].xm !== ex[i] || blkQ[i].ym !== ey[i]) begin errCnt++; $display("FAIL bp_mask[%0d] got %h/%h want %h/%h", i, blkQ[i].xm, blkQ[i].ym, ex[i], ey[i]); end
    end
    vecCnt++; if (fdCnt != 1) begin errCnt++; $display("FAIL bp_frmdone_cnt got %0d want 1", fdCnt); end
  endtask

  task automatic test_fst_restart();
    logic [63:0] ex[4];
    logic [63:0] ey[4];
    ex = '{64'd1, 64'd2, 64'd1, 64'd2};
    ey = '{64'd1, 64'd1, 64'd2, 64'd2};
    blkQ.delete(); fdCnt = 0; bus.CompBlkRdy = 1'b1;
    startFrame(8'd2, 8'd2, 7'd2, 7'd2);
    for (int k = 0; k < 5; k++) pushPx(pix(8'd50), 1'b0);
    pushPx(pix(8'd10), 1'b1);
    for (int k = 0; k < 15; k++) pushPx(pix(8'd10), 1'b0);
    bus.PxlVld = 1'b0;
    idle(3);
    vecCnt++; if (blkQ.size() != 4) begin errCnt++; $display("FAIL fst_count got %0d want 4", blkQ.size()); end
    for (int i = 0; i < blkQ.size() && i < 4; i++) begin
      vecCnt++; if (blkQ[i].d !== s3(40)) begin errCnt++; $display("FAIL fst_sum[%0d] got %h want %h", i, blkQ[i].d, s3(40)); end
      vecCnt++; if (blkQ[i].xm !== ex[i] || blkQ[i].ym !== ey[i]) begin errCnt++; $display("FAIL fst_mask[%0d] got %h/%h want %h/%h", i, blkQ[i].xm, blkQ[i].ym, ex[i], ey[i]); end
    end
    vecCnt++; if (fdCnt != 1) begin errCnt++; $display("FAIL fst_frmdone_cnt got %0d want 1", fdCnt); end
  endtask

  task automatic test_overflow();
    logic [29:0] expD;
    logic        expO;
    int          notRdy;
`ifdef IMG_RSZ_BLK_ACC_SAT_EN
    expD = {3{10'd1023}}; expO = 1'b1;
`else
    expD = {3{10'd1016}}; expO = 1'b0;
`endif
    notRdy = 0;
    bus2.CompBlkRdy = 1'b1;
    BlkSzHor2 = 8'd4; BlkSzVer2 = 8'd2; RszWidth2 = 7'd1; RszHeight2 = 7'd1;
    CompEngRdy2 = 1'b1;
    @(posedge Clk); #1;
    CompEngRdy2 = 1'b0;
    bus2.PxlData = {3{8'd255}}; bus2.PxlVld = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk); if (!bus2.PxlRdy) notRdy++;
      @(posedge Clk); #1;
    end
    bus2.PxlVld = 1'b0;
    vecCnt++; if (notRdy != 0) begin errCnt++; $display("FAIL ovf_pxlrdy stalled %0d cycles want 0", notRdy); end
    @(negedge Clk);
    vecCnt++; if (bus2.CompBlkVld !== 1'b1 || bus2.CompBlkData !== expD) begin errCnt++; $display("FAIL ovf_sum got %b/%h want 1/%h", bus2.CompBlkVld, bus2.CompBlkData, expD); end
    vecCnt++; if (FrmDone2 !== 1'b1) begin errCnt++; $display("FAIL ovf_frmdone got %b want 1", FrmDone2); end
    vecCnt++; if (AccOvf2 !== expO) begin errCnt++; $display("FAIL ovf_flag got %b want %b", AccOvf2, expO); end
    @(posedge Clk); #1;
    idle(2);
    vecCnt++; if (AccOvf2 !== expO || bus2.CompBlkVld !== 1'b0) begin errCnt++; $display("FAIL ovf_sticky got %b/%b want %b/0", AccOvf2, bus2.CompBlkVld, expO); end
  endtask

  task automatic test_reset_mid();
    blkQ.delete(); fdCnt = 0; bus.CompBlkRdy = 1'b0;
    startFrame(8'd2, 8'd2, 7'd2, 7'd2);
    for (int k = 0; k < 6; k++) pushPx(pix(8'd77), 1'b0);
    bus.PxlVld = 1'b0;
    @(negedge Clk);
    vecCnt++; if (bus.CompBlkVld !== 1'b1) begin errCnt++; $display("FAIL rstmid_pending got %b want 1", bus.CompBlkVld); end
    @(posedge Clk); #1;
    Reset = 1'b0;
    #1;
    vecCnt++; if (bus.CompBlkVld !== 1'b0 || bus.CompBlkData !== 60'd0) begin errCnt++; $display("FAIL rstmid_clear got %b/%h want 0/0", bus.CompBlkVld, bus.CompBlkData); end
    vecCnt++; if (bus.CompBlkXMsk !== 64'd0 || bus.PxlRdy !== 1'b0) begin errCnt++; $display("FAIL rstmid_ctrl got %h/%b want 0/0", bus.CompBlkXMsk, bus.PxlRdy); end
    vecCnt++; if (AccOvf2 !== 1'b0) begin errCnt++; $display("FAIL rstmid_ovf2 got %b want 0", AccOvf2); end
    idle(2);
    Reset = 1'b1;
    idle(1);
    bus.CompBlkRdy = 1'b1;
    startFrame(8'd2, 8'd2, 7'd2, 7'd2);
    for (int k = 0; k < 16; k++) pushPx(pix(8'd3), 1'b0);
    bus.PxlVld = 1'b0;
    idle(3);
    vecCnt++; if (blkQ.size() != 4) begin errCnt++; $display("FAIL rstmid_count got %0d want 4", blkQ.size()); end
    if (blkQ.size() > 0) begin
      vecCnt++; if (blkQ[0].d !== s3(12)) begin errCnt++; $display("FAIL rstmid_sum got %h want %h", blkQ[0].d, s3(12)); end
      vecCnt++; if (blkQ[0].xm !== 64'd1 || blkQ[0].ym !== 64'd1) begin errCnt++; $display("FAIL rstmid_mask got %h/%h want 1/1", blkQ[0].xm, blkQ[0].ym); end
    end
    vecCnt++; if (fdCnt != 1) begin errCnt++; $display("FAIL rstmid_frmdone_cnt got %0d want 1", fdCnt); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] ex[3];
    int          ev[3];
    ex = '{64'd1, 64'd2, 64'd4};
    ev = '{5, 6, 7};
    blkQ.delete(); fdCnt = 0; bus.CompBlkRdy = 1'b1;
    startFrame(8'd1, 8'd1, 7'd3, 7'd1);
    for (int k = 0; k < 3; k++) pushPx(pix(8'(ev[k])), 1'b0);
    bus.PxlVld = 1'b0;
    idle(3);
    vecCnt++; if (blkQ.size() != 3) begin errCnt++; $display("FAIL b2b_count got %0d want 3", blkQ.size()); end
    for (int i = 0; i < blkQ.size() && i < 3; i++) begin
      vecCnt++; if (blkQ[i].d !== s3(ev[i])) begin errCnt++; $display("FAIL b2b_sum[%0d] got %h want %h", i, blkQ[i].d, s3(ev[i])); end
      vecCnt++; if (blkQ[i].xm !== ex[i] || blkQ[i].ym !== 64'd1) begin errCnt++; $display("FAIL b2b_mask[%0d] got %h/%h want %h/1", i, blkQ[i].xm, blkQ[i].ym, ex[i]); end
      vecCnt++; if (blkQ[i].cyc !== blkQ[0].cyc + i) begin errCnt++; $display("FAIL b2b_cycle[%0d] got %0d want %0d", i, blkQ[i].cyc, blkQ[0].cyc + i); end
      vecCnt++; if (blkQ[i].fd !== (i == 2)) begin errCnt++; $display("FAIL b2b_frmdone[%0d] got %b want %b", i, blkQ[i].fd, (i == 2)); end
    end
  endtask

  initial begin
    bus.PxlData = '0; bus.PxlVld = 1'b0; bus.IsFstPxl = 1'b0; bus.CompBlkRdy = 1'b0;
    bus2.PxlData = '0; bus2.PxlVld = 1'b0; bus2.IsFstPxl = 1'b0; bus2.CompBlkRdy = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_fst_restart();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
    $finish;
  end
endmodule

// File: doc/img_rsz_blk_acc.md
IMG_RSZ_BLK_ACC -- requirements
Module: img_rsz_blk_acc

Interface
REQ-001 SHALL have parameter PXL_W, 8, bits per primary colour.
REQ-002 SHALL have parameter COLOR_NUM, 3, primary colours per pixel.
REQ-003 SHALL have parameter SUM_W, 20, bits per colour block sum.
REQ-004 SHALL have parameter RSZ_W_MAX, 64, max block columns (one-hot X mask width).
REQ-005 SHALL have parameter RSZ_H_MAX, 64, max block rows (one-hot Y mask width).
REQ-006 SHALL have parameters BLK_W_W and BLK_H_W, 8 each, block size field widths.
REQ-007 SHALL have port Clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port CompEngRdy  in  1  downstream block size valid; frame start gate.
REQ-010 SHALL have ports BlkSzHor  in  BLK_W_W and BlkSzVer  in  BLK_H_W  block width/height in pixels, >=1.
REQ-011 SHALL have ports RszWidth  in  clog2(RSZ_W_MAX+1) and RszHeight  in  clog2(RSZ_H_MAX+1)  block columns/rows per frame, >=1.
REQ-012 SHALL have ports PxlData  in  COLOR_NUM*PXL_W, PxlVld  in  1, PxlRdy  out  1, IsFstPxl  in  1  raster pixel stream.
REQ-013 SHALL have ports CompBlkData  out  COLOR_NUM*SUM_W, CompBlkXMsk  out  RSZ_W_MAX, CompBlkYMsk  out  RSZ_H_MAX, CompBlkVld  out  1, CompBlkRdy  in  1  block output.
REQ-014 SHALL have ports FrmDone  out  1  one-cycle frame-complete pulse, and AccOvf  out  1  sticky sum overflow flag.

Function
REQ-015 SHALL implement FSM IDLE -> ACC (CompEngRdy=1) -> FLUSH (last block sum registered) -> IDLE (final block handshake); FrmDone=1 on that handshake cycle only.
REQ-016 SHALL hold PxlRdy=0 in IDLE and FLUSH; in ACC PxlRdy = !(CompBlkVld && !CompBlkRdy).
REQ-017 SHALL keep per-column accumulators Acc[x][c], x<RszWidth; accepted pixel (PxlVld&&PxlRdy) adds each colour to Acc[BlkX][c].
REQ-018 SHALL track HorCnt (0..BlkSzHor-1), BlkX (0..RszWidth-1), VerCnt (0..BlkSzVer-1), BlkY (0..RszHeight-1) in raster order, each wrapping to 0 and carrying to the next.
REQ-019 SHALL, on accepting a block's last pixel (HorCnt=BlkSzHor-1, VerCnt=BlkSzVer-1), register CompBlkData=Acc[BlkX]+pixel, one-hot masks bit BlkX/BlkY, CompBlkVld=1 next cycle, and clear Acc[BlkX] same edge.
REQ-020 SHALL hold CompBlkData/masks stable while CompBlkVld=1 and CompBlkRdy=0; CompBlkVld drops after handshake unless a new block is registered that cycle.
REQ-021 SHALL allow handshake and new pixel acceptance in the same cycle (full throughput, 1-cycle latency pixel->block).
REQ-022 SHALL, on accepted pixel with IsFstPxl=1 in ACC, zero all counters/accumulators and treat that pixel as first pixel of block (0,0); pending output block unaffected.
REQ-023 SHALL ignore IsFstPxl and PxlData when PxlRdy=0.
REQ-024 SHALL sample BlkSzHor/BlkSzVer/RszWidth/RszHeight on IDLE->ACC and use the sampled copies for the frame.
REQ-025 SHALL for BlkSzHor=BlkSzVer=1 emit every pixel as a block (sum = pixel zero-extended).

Reset
REQ-026 SHALL on Reset=0, asynchronously: FSM=IDLE, counters/accumulators=0, CompBlkVld=0, CompBlkData=0, masks=0, FrmDone=0, AccOvf=0, PxlRdy=0.
REQ-027 SHALL on reset assertion mid-frame discard all partial sums and any pending block; restart only via IDLE.

Configuration
REQ-028 SHALL with IMG_RSZ_BLK_ACC_SAT_EN defined saturate each colour sum at 2^SUM_W-1 and set AccOvf sticky until reset.
REQ-029 SHALL without IMG_RSZ_BLK_ACC_SAT_EN wrap sums modulo 2^SUM_W and tie AccOvf=0.

Verification
REQ-030 SHALL cover: 2x2 blocks, RszWidth=RszHeight=2, 16 pixels all colours=10, Rdy=1 -> 4 blocks sum 40, X masks 01,10,01,10, Y 01,01,10,10, FrmDone after 4th.
REQ-031 SHALL cover: CompBlkRdy=0 for 5 cycles with block pending -> PxlRdy=0, CompBlkData/masks constant, no pixel lost after release.
REQ-032 SHALL cover: IsFstPxl on 6th pixel of REQ-030 frame -> next output blocks restart at X/Y mask 01, sums exclude first 5 pixels.
REQ-033 SHALL cover: SUM_W=10, 4x2 block of 255 -> 1023 and AccOvf=1 with macro; 1016, AccOvf=0 without.
REQ-034 SHALL cover: Reset=0 mid-block then frame restart -> first block sum contains only post-reset pixels.
REQ-035 SHALL cover: 1x1 blocks, RszWidth=3, RszHeight=1, pixels 5,6,7 -> blocks 5,6,7 back-to-back, one per cycle.
